// File: rtl/mos6502_fetch_unit.sv
// 6502 instruction fetch: reads opcode plus 0-2 operand bytes, presents them via valid/ready.
// Define MOS6502_FETCH_PERF_EN to add the instr_count / stall_count counters.
module mos6502_fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [7:0]  NOP_OPCODE = 8'hEA
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic [7:0]  instruction_bus,
    output logic [7:0]  operand_lo,
    output logic [7:0]  operand_hi,
    output logic [1:0]  instr_len,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
`ifdef MOS6502_FETCH_PERF_EN
    output logic [15:0] instr_count,
    output logic [15:0] stall_count,
`endif
    input  logic        pc_load,
    input  logic [15:0] pc_load_addr
);

    typedef enum logic [1:0] {
        FETCH_OP,
        FETCH_LO,
        FETCH_HI,
        PRESENT
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic        mem_req_q;
    logic [7:0]  opcode_q;
    logic [7:0]  bus_q;
    logic [7:0]  lo_q;
    logic [7:0]  hi_q;
    logic [1:0]  len_q;
    logic [15:0] ipc_q;
    logic        valid_q;

    logic        xfer;
    logic        hs;
    logic [1:0]  len_d;
    logic [3:0]  nib;

    assign xfer = mem_req_q & mem_ack;
    assign hs   = valid_q & instr_ready;
    assign nib  = mem_rdata[3:0];

    always_comb begin
        len_d = 2'd2;
        unique case (1'b1)
            (nib == 4'h8) || (nib == 4'hA) || (nib == 4'hB) ||
            (mem_rdata == 8'h00) || (mem_rdata == 8'h40) ||
            (mem_rdata == 8'h60):
                len_d = 2'd1;
            (mem_rdata == 8'h20) || (nib[3:2] == 2'b11) ||
            ((nib == 4'h9) && mem_rdata[4]):
                len_d = 2'd3;
            default:
                len_d = 2'd2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH_OP;
            pc_q      <= RESET_PC;
            mem_req_q <= 1'b0;
            opcode_q  <= NOP_OPCODE;
            bus_q     <= NOP_OPCODE;
            lo_q      <= 8'h00;
            hi_q      <= 8'h00;
            len_q     <= 2'd1;
            ipc_q     <= RESET_PC;
            valid_q   <= 1'b0;
        end else if (pc_load) begin
            // Redirect wins; any byte arriving this cycle is dropped.
            state_q   <= FETCH_OP;
            pc_q      <= pc_load_addr;
            mem_req_q <= 1'b0;
            valid_q   <= 1'b0;
            bus_q     <= NOP_OPCODE;
        end else begin
            case (state_q)
                FETCH_OP: begin
                    if (!mem_req_q) begin
                        mem_req_q <= 1'b1;
                    end else if (xfer) begin
                        opcode_q <= mem_rdata;
                        ipc_q    <= pc_q;
                        lo_q     <= 8'h00;
                        hi_q     <= 8'h00;
                        len_q    <= len_d;
                        pc_q     <= pc_q + 16'd1;
                        if (len_d == 2'd1) begin
                            state_q   <= PRESENT;
                            mem_req_q <= 1'b0;
                            valid_q   <= 1'b1;
                            bus_q     <= mem_rdata;
                        end else begin
                            state_q <= FETCH_LO;
                        end
                    end
                end
                FETCH_LO: begin
                    if (xfer) begin
                        lo_q <= mem_rdata;
                        pc_q <= pc_q + 16'd1;
                        if (len_q == 2'd2) begin
                            state_q   <= PRESENT;
                            mem_req_q <= 1'b0;
                            valid_q   <= 1'b1;
                            bus_q     <= opcode_q;
                        end else begin
                            state_q <= FETCH_HI;
                        end
                    end
                end
                FETCH_HI: begin
                    if (xfer) begin
                        hi_q      <= mem_rdata;
                        pc_q      <= pc_q + 16'd1;
                        state_q   <= PRESENT;
                        mem_req_q <= 1'b0;
                        valid_q   <= 1'b1;
                        bus_q     <= opcode_q;
                    end
                end
                PRESENT: begin
                    if (hs) begin
                        state_q   <= FETCH_OP;
                        mem_req_q <= 1'b1;
                        valid_q   <= 1'b0;
                        bus_q     <= NOP_OPCODE;
                    end
                end
                default: state_q <= FETCH_OP;
            endcase
        end
    end

`ifdef MOS6502_FETCH_PERF_EN
    logic [15:0] icnt_q;
    logic [15:0] scnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            icnt_q <= 16'h0000;
            scnt_q <= 16'h0000;
        end else begin
            if (hs) icnt_q <= icnt_q + 16'd1;
            if (mem_req_q && !mem_ack) scnt_q <= scnt_q + 16'd1;
        end
    end

    assign instr_count = icnt_q;
    assign stall_count = scnt_q;
`endif

    assign mem_req         = mem_req_q;
    assign mem_addr        = pc_q;
    assign instruction_bus = bus_q;
    assign operand_lo      = lo_q;
    assign operand_hi      = hi_q;
    assign instr_len       = len_q;
    assign instr_pc        = ipc_q;
    assign instr_valid     = valid_q;

endmodule
